// File: rtl/inst_fetch_if.sv
// Fetch-side bundle: byte-wide program memory port, decoder handshake and redirect.
// master = fetch unit, slave = the memory/decoder side driving it.
interface inst_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic [15:0]       inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] pc;

    modport master (
        output mem_req, mem_addr, inst, inst_valid, pc,
        input  mem_ack, mem_data, inst_ready, jump_en, jump_addr
    );

    modport slave (
        input  mem_req, mem_addr, inst, inst_valid, pc,
        output mem_ack, mem_data, inst_ready, jump_en, jump_addr
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles big-endian 16-bit instructions from a byte-wide memory
// and hands them to the decoder. Define PREFETCH_EN to add a one-entry prefetch buffer.
module inst_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, FETCH_HI, FETCH_LO, HOLD} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fp_q, fp_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        hi_q, hi_d;
    logic [15:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
`ifdef PREFETCH_EN
    logic [15:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic              buf_valid_q, buf_valid_d;
`endif

    logic        consume;
    logic        new_word;
    logic [15:0] word;

    assign consume  = inst_valid_q && bus.inst_ready;
    assign new_word = (state_q == FETCH_LO) && bus.mem_ack;
    assign word     = {hi_q, bus.mem_data};

    always_comb begin
        state_d      = state_q;
        fp_d         = fp_q;
        pc_d         = pc_q;
        hi_d         = hi_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
`ifdef PREFETCH_EN
        buf_d        = buf_q;
        buf_pc_d     = buf_pc_q;
        buf_valid_d  = buf_valid_q;
`endif
        if (bus.jump_en) begin
            // Redirect wins over ack and ready; any partial hi byte is simply overwritten later.
            state_d      = FETCH_HI;
            fp_d         = bus.jump_addr & ~ADDR_W'(1);
            inst_valid_d = 1'b0;
`ifdef PREFETCH_EN
            buf_valid_d  = 1'b0;
`endif
        end else begin
`ifdef PREFETCH_EN
            if (consume) begin
                if (buf_valid_q) begin
                    inst_d      = buf_q;
                    pc_d        = buf_pc_q;
                    buf_valid_d = 1'b0;
                end else begin
                    inst_valid_d = 1'b0;
                end
            end
            // A completed word fills inst if it is free after this edge, otherwise the buffer.
            if (new_word) begin
                if (!inst_valid_d) begin
                    inst_d       = word;
                    pc_d         = fp_q;
                    inst_valid_d = 1'b1;
                end else begin
                    buf_d        = word;
                    buf_pc_d     = fp_q;
                    buf_valid_d  = 1'b1;
                end
            end
`else
            if (consume) begin
                inst_valid_d = 1'b0;
            end
            if (new_word) begin
                inst_d       = word;
                pc_d         = fp_q;
                inst_valid_d = 1'b1;
            end
`endif
            case (state_q)
                IDLE: state_d = FETCH_HI;
                FETCH_HI: begin
                    if (bus.mem_ack) begin
                        hi_d    = bus.mem_data;
                        state_d = FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (bus.mem_ack) begin
                        fp_d = fp_q + ADDR_W'(2);
`ifdef PREFETCH_EN
                        state_d = (inst_valid_d && buf_valid_d) ? HOLD : FETCH_HI;
`else
                        state_d = HOLD;
`endif
                    end
                end
                HOLD: begin
                    if (consume) begin
                        state_d = FETCH_HI;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fp_q         <= '0;
            pc_q         <= '0;
            hi_q         <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
`ifdef PREFETCH_EN
            buf_q        <= '0;
            buf_pc_q     <= '0;
            buf_valid_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            fp_q         <= fp_d;
            pc_q         <= pc_d;
            hi_q         <= hi_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
`ifdef PREFETCH_EN
            buf_q        <= buf_d;
            buf_pc_q     <= buf_pc_d;
            buf_valid_q  <= buf_valid_d;
`endif
        end
    end

    assign bus.mem_req    = (state_q == FETCH_HI) || (state_q == FETCH_LO);
    assign bus.mem_addr   = (state_q == FETCH_LO) ? fp_q + ADDR_W'(1) : fp_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.pc         = pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: directed programs, a byte memory model with
// configurable wait states, and a monitor that pops expected instructions on handshake.
module tb_inst_fetch;

    logic clk;
    logic rst;

    inst_fetch_if #(.ADDR_W(8)) bus ();

    inst_fetch #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] inst;
        logic [7:0]  pc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         wait_n   = 0;
    int         acks     = 0;
    int         addr_chg = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic push(input logic [15:0] i, input logic [7:0] p);
        exp_t e;
        e.inst = i;
        e.pc   = p;
        sb.push_back(e);
    endtask

    // Raise ready until every expected instruction has been handed over, then drop it.
    task automatic drain(input int budget);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < budget && sb.size() != 0; i++) tick();
        bus.inst_ready = 1'b0;
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        bus.inst_ready = 1'b0;
        bus.jump_en    = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        sb.delete();
        rst = 1'b0;
    endtask

    // Byte memory: answers after wait_n unacked cycles, tracks request stability.
    initial begin
        logic [7:0] last_addr;
        int cnt;
        cnt = 0;
        last_addr = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(negedge clk);
            if (cnt > 0 && (!bus.mem_req || bus.mem_addr != last_addr)) addr_chg++;
            last_addr = bus.mem_addr;
            if (bus.mem_req && cnt >= wait_n) begin
                bus.mem_ack  = 1'b1;
                bus.mem_data = mem[bus.mem_addr];
                acks++;
                cnt = 0;
            end else if (bus.mem_req) begin
                bus.mem_ack = 1'b0;
                cnt++;
            end else begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: any accepted instruction must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (bus.inst_valid && bus.inst_ready && !bus.jump_en && !rst) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_inst: got %0h pc %0h expected none", bus.inst, bus.pc);
                end else begin
                    e = sb.pop_front();
                    check("inst", bus.inst, e.inst);
                    check("pc", bus.pc, e.pc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'h84; mem[3] = 8'h05;
        rst            = 1'b1;
        bus.inst_ready = 1'b0;
        bus.jump_en    = 1'b0;
        bus.jump_addr  = '0;
        tick();
        tick();
        check("rst_valid", bus.inst_valid, 0);
        check("rst_inst", bus.inst, 16'h0000);
        check("rst_pc", bus.pc, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);

        // Basic fetch: request on cycle 1, instruction valid on cycle 3.
        push(16'h8012, 8'h00);
        rst = 1'b0;
        tick();
        check("c1_mem_req", bus.mem_req, 1);
        check("c1_mem_addr", bus.mem_addr, 8'h00);
        check("c1_valid", bus.inst_valid, 0);
        tick();
        check("c2_mem_addr", bus.mem_addr, 8'h01);
        check("c2_valid", bus.inst_valid, 0);
        tick();
        check("c3_valid", bus.inst_valid, 1);

        // Decoder stall: everything holds and no memory traffic.
        for (int i = 0; i < 5; i++) begin
            check("stall_inst", bus.inst, 16'h8012);
            check("stall_pc", bus.pc, 8'h00);
            check("stall_valid", bus.inst_valid, 1);
            check("stall_mem_req", bus.mem_req, 0);
            tick();
        end
        push(16'h8405, 8'h02);
        drain(20);

        // Slow memory: three wait cycles per byte.
        do_reset();
        wait_n   = 3;
        acks     = 0;
        addr_chg = 0;
        push(16'h8012, 8'h00);
        push(16'h8405, 8'h02);
        drain(60);
        check("slow_acks", acks, 4);
        check("slow_addr_stable", addr_chg, 0);

        // Jump to the top of memory and wrap to address 0.
        wait_n = 0;
        mem[8'hFE] = 8'h08; mem[8'hFF] = 8'h00; mem[0] = 8'h00; mem[1] = 8'h00;
        do_reset();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'hFE;
        tick();
        bus.jump_en = 1'b0;
        check("wrap_mem_addr", bus.mem_addr, 8'hFE);
        check("wrap_mem_req", bus.mem_req, 1);
        push(16'h0800, 8'hFE);
        push(16'h0000, 8'h00);
        drain(20);

        // Jump coincident with the hi-byte ack; odd target is aligned down.
        mem[0] = 8'h80; mem[1] = 8'h12;
        mem[8'h10] = 8'hC3; mem[8'h11] = 8'h3C; mem[8'h12] = 8'h5A; mem[8'h13] = 8'hA5;
        do_reset();
        tick();
        bus.jump_en   = 1'b1;
        bus.jump_addr = 8'h11;
        tick();
        bus.jump_en = 1'b0;
        check("jmp_mem_addr", bus.mem_addr, 8'h10);
        check("jmp_mem_req", bus.mem_req, 1);
        check("jmp_valid_c2", bus.inst_valid, 0);
        tick();
        check("jmp_lo_addr", bus.mem_addr, 8'h11);
        check("jmp_valid_c3", bus.inst_valid, 0);
        push(16'hC33C, 8'h10);
        drain(10);

        // Asynchronous reset while the lo byte of the next instruction is requested.
        tick();
        check("pre_rst_mem_addr", bus.mem_addr, 8'h13);
        check("pre_rst_mem_req", bus.mem_req, 1);
        rst = 1'b1;
        #1;
        check("arst_mem_req", bus.mem_req, 0);
        check("arst_mem_addr", bus.mem_addr, 0);
        check("arst_inst", bus.inst, 16'h0000);
        check("arst_pc", bus.pc, 0);
        check("arst_valid", bus.inst_valid, 0);
        tick();
        rst = 1'b0;
        push(16'h8012, 8'h00);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
